// File: rtl/mem_stage.sv
// MEM pipeline stage: captures the EX->MEM bus, waits for or buffers load data
// from the data SRAM, aligns it, and presents the MEM->WB and forwarding outputs.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 79,
  parameter int MEM_TO_WB_WD = 70,
  parameter int StallBus     = 6
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [StallBus-1:0]       stall,
  input  logic [EX_TO_MEM_WD-1:0]   ex_to_mem_bus,
  input  logic [31:0]               data_sram_rdata,
  input  logic                      data_sram_rvalid,
  output logic [MEM_TO_WB_WD-1:0]   mem_to_wb_bus,
  output logic                      mem_wreg,
  output logic [4:0]                mem_waddr,
  output logic [31:0]               mem_wdata,
  output logic                      stallreq_for_mem
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Little-endian load alignment with sign/zero extension; unknown ops act as lw.
  function automatic logic [31:0] align_load(input logic [2:0]  op,
                                             input logic [1:0]  off,
                                             input logic [31:0] raw);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    case (off)
      2'd0:    byte_v = raw[7:0];
      2'd1:    byte_v = raw[15:8];
      2'd2:    byte_v = raw[23:16];
      2'd3:    byte_v = raw[31:24];
      default: byte_v = raw[7:0];
    endcase
    half_v = off[1] ? raw[31:16] : raw[15:0];
    case (op)
      OP_LB:   res_v = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  res_v = {24'h00_0000, byte_v};
      OP_LH:   res_v = {{16{half_v[15]}}, half_v};
      OP_LHU:  res_v = {16'h0000, half_v};
      OP_LW:   res_v = raw;
      default: res_v = raw;
    endcase
    return res_v;
  endfunction

  logic [EX_TO_MEM_WD-1:0] bus_d, bus_q;
  logic [31:0]             buf_d, buf_q;
  state_t                  state_d, state_q;

  logic [31:0] mem_pc_s;
  logic [2:0]  mem_op_s;
  logic        data_ram_en_s;
  logic [3:0]  data_ram_wen_s;
  logic        sel_rf_res_s;
  logic        rf_we_s;
  logic [4:0]  rf_waddr_s;
  logic [31:0] ex_result_s;
  logic        is_load_s;
  logic [31:0] raw_s;
  logic [31:0] load_data_s;
  logic [31:0] rf_wdata_s;
  logic        stallreq_s;
  logic        unused_stall_s;

  assign unused_stall_s = ^stall;

  assign mem_pc_s       = bus_q[78:47];
  assign mem_op_s       = bus_q[46:44];
  assign data_ram_en_s  = bus_q[43];
  assign data_ram_wen_s = bus_q[42:39];
  assign sel_rf_res_s   = bus_q[38];
  assign rf_we_s        = bus_q[37];
  assign rf_waddr_s     = bus_q[36:32];
  assign ex_result_s    = bus_q[31:0];

  assign is_load_s = data_ram_en_s & (data_ram_wen_s == 4'b0000);

  // Pipeline register next value: bubble when MEM stops but WB runs, else load or hold.
  always_comb begin
    bus_d = bus_q;
    if (stall[3] && !stall[4]) begin
      bus_d = {EX_TO_MEM_WD{1'b0}};
    end else if (!stall[3]) begin
      bus_d = ex_to_mem_bus;
    end else begin
      bus_d = bus_q;
    end
  end

  // Load handshake FSM: IDLE issues, WAIT covers late data, HOLD keeps data across a stall.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    stallreq_s = 1'b0;
    raw_s      = data_sram_rdata;
    case (state_q)
      ST_IDLE: begin
        if (is_load_s) begin
          if (!data_sram_rvalid) begin
            stallreq_s = 1'b1;
            state_d    = ST_WAIT;
          end else if (stall[3]) begin
            buf_d   = data_sram_rdata;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!data_sram_rvalid) begin
          stallreq_s = 1'b1;
          state_d    = ST_WAIT;
        end else if (stall[3]) begin
          buf_d   = data_sram_rdata;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        raw_s = buf_q;
        if (!stall[3]) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Write-back data selection between aligned load data and the ALU result.
  always_comb begin
    load_data_s = align_load(mem_op_s, ex_result_s[1:0], raw_s);
    if (sel_rf_res_s) begin
      rf_wdata_s = load_data_s;
    end else begin
      rf_wdata_s = ex_result_s;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_q   <= {EX_TO_MEM_WD{1'b0}};
      buf_q   <= 32'h0000_0000;
      state_q <= ST_IDLE;
    end else begin
      bus_q   <= bus_d;
      buf_q   <= buf_d;
      state_q <= state_d;
    end
  end

  assign mem_to_wb_bus    = MEM_TO_WB_WD'({mem_pc_s, rf_we_s, rf_waddr_s, rf_wdata_s});
  assign mem_wreg         = rf_we_s;
  assign mem_waddr        = rf_waddr_s;
  assign mem_wdata        = rf_wdata_s;
  assign stallreq_for_mem = stallreq_s;

endmodule
